// File: rtl/ru_alloc_scheduler.sv
// ru_alloc_scheduler
// Maps faulty systolic columns onto redundant recompute units (RUs) and
// sequences each recompute pass (stationary-weight load, then run).
// A column is faulty when any PE in it failed. Columns are scanned in
// ascending order, one per cycle, and RUs are handed out lowest index first.
// Every output comes straight from a flop.

module ru_alloc_scheduler #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4,
    localparam int CB    = $clog2(COLS),
    localparam int RB    = (NUM_RU > 1) ? $clog2(NUM_RU) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stw_complete,
    input  logic [ROWS*COLS-1:0]   stw_fault_flat,
    input  logic                   recompute_start,
    input  logic                   recompute_last,
    output logic [NUM_RU-1:0]      ru_en,
    output logic [CB*NUM_RU-1:0]   ru_col_mapping,
    output logic [COLS-1:0]        col_ru_valid,
    output logic [RB*COLS-1:0]     col_ru_idx,
    output logic [NUM_RU-1:0]      ru_set_stationary,
    output logic [NUM_RU-1:0]      ru_stat_bit_in,
    output logic [NUM_RU-1:0]      ru_fsm_out_sel_in,
    output logic                   alloc_done,
    output logic                   alloc_overflow,
    output logic [CB:0]            fault_col_count,
    output logic                   busy,
    output logic                   recompute_done
);

    // KW holds the next-free RU index, which may reach NUM_RU (all used).
    localparam int KW = $clog2(NUM_RU + 1);
    localparam int LW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ARMED = 3'd2,
        ST_LOAD  = 3'd3,
        ST_RUN   = 3'd4
    } state_e;

    // Per-column OR of all row fault bits.
    function automatic logic [COLS-1:0] fault_cols(input logic [ROWS*COLS-1:0] flat);
        logic [COLS-1:0] acc;
        acc = {COLS{1'b0}};
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                acc[c] = acc[c] | flat[r*COLS + c];
            end
        end
        return acc;
    endfunction

    state_e                 state_q, state_d;
    logic                   stw_q;
    logic                   pending_q, pending_d;
    logic [CB-1:0]          col_q, col_d;
    logic [KW-1:0]          k_q, k_d;
    logic [LW-1:0]          load_cnt_q, load_cnt_d;

    logic [NUM_RU-1:0]      ru_en_q, ru_en_d;
    logic [CB*NUM_RU-1:0]   map_q, map_d;
    logic [COLS-1:0]        cv_q, cv_d;
    logic [RB*COLS-1:0]     ci_q, ci_d;
    logic                   alloc_done_q, alloc_done_d;
    logic                   ovf_q, ovf_d;
    logic [CB:0]            count_q, count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_RU-1:0]      set_stat_q, set_stat_d;
    logic [NUM_RU-1:0]      stat_bit_q, stat_bit_d;
    logic [NUM_RU-1:0]      out_sel_q, out_sel_d;

    logic                   rise_s;
    logic [COLS-1:0]        fcols_s;
    logic [COLS-1:0]        col_sel_s;
    logic [NUM_RU-1:0]      ru_sel_s;
    logic                   cur_fault_s;

    // Edge detect on the STW done level and one-hot selects for the current column / next-free RU.
    always_comb begin
        rise_s      = stw_complete & ~stw_q;
        fcols_s     = fault_cols(stw_fault_flat);
        col_sel_s   = COLS'(1'b1) << col_q;
        ru_sel_s    = NUM_RU'(1'b1) << k_q;
        cur_fault_s = |(fcols_s & col_sel_s);
    end

    // Next-state logic: scan/allocation, pass sequencing and registered output values.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        col_d        = col_q;
        k_d          = k_q;
        load_cnt_d   = load_cnt_q;
        ru_en_d      = ru_en_q;
        map_d        = map_q;
        cv_d         = cv_q;
        ci_d         = ci_q;
        alloc_done_d = alloc_done_q;
        ovf_d        = ovf_q;
        count_d      = count_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d      = ST_SCAN;
                    col_d        = {CB{1'b0}};
                    k_d          = {KW{1'b0}};
                    ru_en_d      = {NUM_RU{1'b0}};
                    map_d        = {(CB*NUM_RU){1'b0}};
                    cv_d         = {COLS{1'b0}};
                    ci_d         = {(RB*COLS){1'b0}};
                    count_d      = {(CB+1){1'b0}};
                    alloc_done_d = 1'b0;
                    ovf_d        = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (rise_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (cur_fault_s) begin
                    count_d = count_q + 1'b1;
                    if (k_q < KW'(NUM_RU)) begin
                        ru_en_d = ru_en_q | ru_sel_s;
                        cv_d    = cv_q | col_sel_s;
                        for (int i = 0; i < NUM_RU; i++) begin
                            if (ru_sel_s[i]) begin
                                map_d[i*CB +: CB] = col_q;
                            end else begin
                                map_d[i*CB +: CB] = map_q[i*CB +: CB];
                            end
                        end
                        for (int c = 0; c < COLS; c++) begin
                            if (col_sel_s[c]) begin
                                ci_d[c*RB +: RB] = RB'(k_q);
                            end else begin
                                ci_d[c*RB +: RB] = ci_q[c*RB +: RB];
                            end
                        end
                        k_d = k_q + 1'b1;
                    end else begin
                        // Out of spare units: column stays unmapped.
                        ovf_d = 1'b1;
                    end
                end else begin
                    count_d = count_q;
                end
                if (col_q == CB'(COLS - 1)) begin
                    state_d      = ST_ARMED;
                    alloc_done_d = 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            ST_ARMED: begin
                if (recompute_start) begin
                    // A simultaneous STW edge is remembered for after the pass.
                    if (rise_s) begin
                        pending_d = 1'b1;
                    end else begin
                        pending_d = pending_q;
                    end
                    if (|ru_en_q) begin
                        state_d    = ST_LOAD;
                        load_cnt_d = {LW{1'b0}};
                    end else begin
                        // Nothing to recompute: acknowledge immediately.
                        done_d = 1'b1;
                    end
                end else if (rise_s || pending_q) begin
                    state_d      = ST_SCAN;
                    pending_d    = 1'b0;
                    col_d        = {CB{1'b0}};
                    k_d          = {KW{1'b0}};
                    ru_en_d      = {NUM_RU{1'b0}};
                    map_d        = {(CB*NUM_RU){1'b0}};
                    cv_d         = {COLS{1'b0}};
                    ci_d         = {(RB*COLS){1'b0}};
                    count_d      = {(CB+1){1'b0}};
                    alloc_done_d = 1'b0;
                    ovf_d        = 1'b0;
                end else begin
                    state_d = ST_ARMED;
                end
            end

            ST_LOAD: begin
                if (rise_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (load_cnt_q == LW'(ROWS - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (rise_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (recompute_last) begin
                    state_d = ST_ARMED;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase

        // Control vectors and busy follow the state being entered.
        busy_d = (state_d == ST_SCAN) || (state_d == ST_LOAD) || (state_d == ST_RUN);
        if (state_d == ST_LOAD) begin
            set_stat_d = ru_en_d;
            stat_bit_d = ru_en_d;
            out_sel_d  = {NUM_RU{1'b0}};
        end else if (state_d == ST_RUN) begin
            set_stat_d = {NUM_RU{1'b0}};
            stat_bit_d = ru_en_d;
            out_sel_d  = ru_en_d;
        end else begin
            set_stat_d = {NUM_RU{1'b0}};
            stat_bit_d = {NUM_RU{1'b0}};
            out_sel_d  = {NUM_RU{1'b0}};
        end
    end

    // State, allocation and output registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            stw_q        <= 1'b0;
            pending_q    <= 1'b0;
            col_q        <= {CB{1'b0}};
            k_q          <= {KW{1'b0}};
            load_cnt_q   <= {LW{1'b0}};
            ru_en_q      <= {NUM_RU{1'b0}};
            map_q        <= {(CB*NUM_RU){1'b0}};
            cv_q         <= {COLS{1'b0}};
            ci_q         <= {(RB*COLS){1'b0}};
            alloc_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            count_q      <= {(CB+1){1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            set_stat_q   <= {NUM_RU{1'b0}};
            stat_bit_q   <= {NUM_RU{1'b0}};
            out_sel_q    <= {NUM_RU{1'b0}};
        end else begin
            state_q      <= state_d;
            stw_q        <= stw_complete;
            pending_q    <= pending_d;
            col_q        <= col_d;
            k_q          <= k_d;
            load_cnt_q   <= load_cnt_d;
            ru_en_q      <= ru_en_d;
            map_q        <= map_d;
            cv_q         <= cv_d;
            ci_q         <= ci_d;
            alloc_done_q <= alloc_done_d;
            ovf_q        <= ovf_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            set_stat_q   <= set_stat_d;
            stat_bit_q   <= stat_bit_d;
            out_sel_q    <= out_sel_d;
        end
    end

    assign ru_en             = ru_en_q;
    assign ru_col_mapping    = map_q;
    assign col_ru_valid      = cv_q;
    assign col_ru_idx        = ci_q;
    assign ru_set_stationary = set_stat_q;
    assign ru_stat_bit_in    = stat_bit_q;
    assign ru_fsm_out_sel_in = out_sel_q;
    assign alloc_done        = alloc_done_q;
    assign alloc_overflow    = ovf_q;
    assign fault_col_count   = count_q;
    assign busy              = busy_q;
    assign recompute_done    = done_q;

endmodule
